// File: rtl/dmem_ctrl_pkg.sv
// Shared types for the data-memory access controller: FSM states, operation codes, port ids.
package dmem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: a collision goes to the pointer port; the pointer moves
// to the loser whenever a grant is accepted.
module rr_arbiter2
  import dmem_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_accept,
  output logic       o_valid,
  output logic       o_grant
);

  logic r_ptr;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    o_valid = |i_req;
    o_grant = PORT0;
    if (i_req == 2'b11) begin
      o_grant = r_ptr;
    end else if (i_req[1]) begin
      o_grant = PORT1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments only.
    if (rst) begin
      r_ptr <= PORT0;
    end else if (i_accept && o_valid) begin
      r_ptr <= ~o_grant;
    end
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Shares one data memory between the CPU (port 0) and the loader (port 1): one access in
// flight, requesters stalled until DONE, stuck accesses aborted after TIMEOUT cycles.
module dmem_access_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd0,
  input  logic              wr0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic [DATA_W-1:0] rdata0,
  output logic              busy_wait0,
  input  logic              rd1,
  input  logic              wr1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy_wait1,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_busy,
  output logic              err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t              r_state;
  state_t              w_next;
  logic                r_owner;
  op_t                 r_op;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_rdata0;
  logic [DATA_W-1:0]   r_rdata1;
  logic                r_err;

  logic                w_req0;
  logic                w_req1;
  logic                w_illegal;
  logic                w_valid;
  logic                w_grant;
  logic                w_accept;
  logic                w_access_ok;
  logic                w_timeout;
  logic                w_sel_wr;

  // Both rd and wr high is a protocol error, not a request.
  assign w_req0    = rd0 ^ wr0;
  assign w_req1    = rd1 ^ wr1;
  assign w_illegal = (rd0 & wr0) | (rd1 & wr1);

  rr_arbiter2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .i_req    ({w_req1, w_req0}),
    .i_accept (w_accept),
    .o_valid  (w_valid),
    .o_grant  (w_grant)
  );

  assign w_accept    = (r_state == ST_IDLE) && w_valid;
  assign w_sel_wr    = (w_grant == PORT1) ? wr1 : wr0;
  // Completion wins over timeout when both happen in the last allowed cycle.
  assign w_access_ok = (r_state == ST_ACCESS) && (r_cnt != '0) && !mem_busy;
  assign w_timeout   = (r_state == ST_ACCESS) && !w_access_ok &&
                       (r_cnt == CNT_W'(TIMEOUT - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_valid) w_next = ST_ACCESS;
      ST_ACCESS: begin
        if (w_access_ok)    w_next = ST_DONE;
        else if (w_timeout) w_next = ST_IDLE;
      end
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_owner  <= PORT0;
      r_op     <= OP_READ;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_cnt    <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_illegal || w_timeout) begin
        r_err <= 1'b1;
      end
      if (w_accept) begin
        r_owner <= w_grant;
        r_op    <= w_sel_wr ? OP_WRITE : OP_READ;
        r_addr  <= (w_grant == PORT1) ? addr1 : addr0;
        r_wdata <= (w_grant == PORT1) ? wdata1 : wdata0;
        r_cnt   <= '0;
      end
      if (r_state == ST_ACCESS) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_access_ok && (r_op == OP_READ)) begin
        if (r_owner == PORT1) r_rdata1 <= mem_rdata;
        else                  r_rdata0 <= mem_rdata;
      end
    end
  end

  assign mem_read   = (r_state == ST_ACCESS) && (r_op == OP_READ);
  assign mem_write  = (r_state == ST_ACCESS) && (r_op == OP_WRITE);
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign rdata0     = r_rdata0;
  assign rdata1     = r_rdata1;
  assign err        = r_err;
  assign busy_wait0 = w_req0 && !((r_state == ST_DONE) && (r_owner == PORT0));
  assign busy_wait1 = w_req1 && !((r_state == ST_DONE) && (r_owner == PORT1));

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a small behavioural data memory whose busy time
// is programmable and which can be forced stuck-busy.
module tb_dmem_access_ctrl;

  localparam int TO = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic       rd0, wr0, rd1, wr1;
  logic [7:0] addr0, wdata0, addr1, wdata1;
  logic [7:0] rdata0, rdata1;
  logic       busy_wait0, busy_wait1;
  logic       mem_read, mem_write;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       mem_busy;
  logic       err;

  int total = 0;
  int bad   = 0;

  logic [7:0] tb_mem [256];
  int         busy_cfg = 0;
  int         busy_cnt = 0;
  logic       stuck    = 1'b0;

  always #5 clk = ~clk;

  // Memory model: busy for busy_cfg cycles after a strobe rises, writes on the ready cycle.
  always @(posedge clk) begin
    if (mem_read || mem_write) busy_cnt <= busy_cnt + 1;
    else                       busy_cnt <= 0;
    if (mem_write && !mem_busy) tb_mem[mem_addr] <= mem_wdata;
  end
  assign mem_busy  = stuck || ((mem_read || mem_write) && (busy_cnt < busy_cfg));
  assign mem_rdata = tb_mem[mem_addr];

  dmem_access_ctrl #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .rd0        (rd0),
    .wr0        (wr0),
    .addr0      (addr0),
    .wdata0     (wdata0),
    .rdata0     (rdata0),
    .busy_wait0 (busy_wait0),
    .rd1        (rd1),
    .wr1        (wr1),
    .addr1      (addr1),
    .wdata1     (wdata1),
    .rdata1     (rdata1),
    .busy_wait1 (busy_wait1),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_busy   (mem_busy),
    .err        (err)
  );

  task automatic do_reset();
    rst = 1'b1;
    rd0 = 1'b0; wr0 = 1'b0; addr0 = '0; wdata0 = '0;
    rd1 = 1'b0; wr1 = 1'b0; addr1 = '0; wdata1 = '0;
    stuck = 1'b0; busy_cfg = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic req(input int p, input logic is_wr, input logic [7:0] a, input logic [7:0] d);
    if (p == 0) begin rd0 = !is_wr; wr0 = is_wr; addr0 = a; wdata0 = d; end
    else        begin rd1 = !is_wr; wr1 = is_wr; addr1 = a; wdata1 = d; end
  endtask

  task automatic drop(input int p);
    if (p == 0) begin rd0 = 1'b0; wr0 = 1'b0; end
    else        begin rd1 = 1'b0; wr1 = 1'b0; end
  endtask

  // Waits (bounded) for the port's stall to lift; returns in the DONE cycle at a negedge.
  task automatic wait_port(input int p, output int cycles, output int strobes, output logic ok);
    ok = 1'b0; cycles = 0; strobes = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      cycles++;
      if (((p == 0) ? busy_wait0 : busy_wait1) == 1'b0) begin
        ok = 1'b1;
        break;
      end
      if (mem_read || mem_write) strobes++;
    end
  endtask

  task automatic serve_both(output int first, output logic ok, output logic other_stalled);
    logic p0, p1;
    p0 = 1'b1; p1 = 1'b1; first = -1; ok = 1'b0; other_stalled = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (p0 && !busy_wait0) begin
        if (first < 0) begin first = 0; other_stalled = busy_wait1; end
        p0 = 1'b0; drop(0);
      end
      if (p1 && !busy_wait1) begin
        if (first < 0) begin first = 1; other_stalled = busy_wait0; end
        p1 = 1'b0; drop(1);
      end
      if (!p0 && !p1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    total++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin bad++; $display("FAIL reset_strobes got=%b%b exp=00", mem_read, mem_write); end
    total++; if (rdata0 !== 8'h00 || rdata1 !== 8'h00) begin bad++; $display("FAIL reset_rdata got=%h/%h exp=00/00", rdata0, rdata1); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
    total++; if (busy_wait0 !== 1'b0 || busy_wait1 !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b%b exp=00", busy_wait0, busy_wait1); end
  endtask

  task automatic test_write();
    int cyc, stb;
    logic ok;
    @(posedge clk); #1;
    busy_cfg = 3;
    req(0, 1'b1, 8'h10, 8'h5A);
    wait_port(0, cyc, stb, ok);
    total++; if (!ok) begin bad++; $display("FAIL wr_timeout got=stalled exp=done"); end
    total++; if (cyc !== 6) begin bad++; $display("FAIL wr_latency got=%0d exp=6", cyc); end
    total++; if (stb !== 4) begin bad++; $display("FAIL wr_strobe_cycles got=%0d exp=4", stb); end
    total++; if (mem_write !== 1'b0) begin bad++; $display("FAIL wr_done_strobe got=%b exp=0", mem_write); end
    total++; if (mem_addr !== 8'h10 || mem_wdata !== 8'h5A) begin bad++; $display("FAIL wr_latched got=%h/%h exp=10/5a", mem_addr, mem_wdata); end
    total++; if (tb_mem[8'h10] !== 8'h5A) begin bad++; $display("FAIL wr_mem got=%h exp=5a", tb_mem[8'h10]); end
    drop(0);
  endtask

  task automatic test_read();
    int cyc, stb;
    logic ok;
    @(posedge clk); #1;
    busy_cfg = 1;
    req(1, 1'b0, 8'h10, 8'h00);
    wait_port(1, cyc, stb, ok);
    total++; if (!ok) begin bad++; $display("FAIL rd_timeout got=stalled exp=done"); end
    total++; if (cyc !== 4 || stb !== 2) begin bad++; $display("FAIL rd_latency got=%0d/%0d exp=4/2", cyc, stb); end
    total++; if (rdata1 !== 8'h5A) begin bad++; $display("FAIL rd_rdata1 got=%h exp=5a", rdata1); end
    total++; if (rdata0 !== 8'h00) begin bad++; $display("FAIL rd_rdata0_untouched got=%h exp=00", rdata0); end
    total++; if (mem_read !== 1'b0) begin bad++; $display("FAIL rd_done_strobe got=%b exp=0", mem_read); end
    drop(1);
  endtask

  task automatic test_back_to_back();
    int first, cyc, stb;
    logic ok, stalled;
    do_reset();
    @(posedge clk); #1;
    req(0, 1'b1, 8'h30, 8'hC3);
    req(1, 1'b1, 8'h31, 8'h33);
    serve_both(first, ok, stalled);
    total++; if (!ok || first !== 0) begin bad++; $display("FAIL rr_first_collision got=%0d ok=%b exp=0", first, ok); end
    total++; if (stalled !== 1'b1) begin bad++; $display("FAIL rr_loser_stalled got=%b exp=1", stalled); end
    @(posedge clk); #1;
    req(0, 1'b0, 8'h31, 8'h00);
    req(1, 1'b0, 8'h30, 8'h00);
    serve_both(first, ok, stalled);
    total++; if (!ok || first !== 0) begin bad++; $display("FAIL rr_second_collision got=%0d ok=%b exp=0", first, ok); end
    total++; if (rdata0 !== 8'h33 || rdata1 !== 8'hC3) begin bad++; $display("FAIL rr_rdata got=%h/%h exp=33/c3", rdata0, rdata1); end
    @(posedge clk); #1;
    req(0, 1'b0, 8'h10, 8'h00);
    wait_port(0, cyc, stb, ok);
    drop(0);
    total++; if (!ok || rdata0 !== 8'h5A) begin bad++; $display("FAIL rr_solo_read got=%h ok=%b exp=5a", rdata0, ok); end
    @(posedge clk); #1;
    req(0, 1'b0, 8'h30, 8'h00);
    req(1, 1'b0, 8'h31, 8'h00);
    serve_both(first, ok, stalled);
    total++; if (!ok || first !== 1) begin bad++; $display("FAIL rr_third_collision got=%0d ok=%b exp=1", first, ok); end
  endtask

  task automatic test_illegal();
    do_reset();
    @(posedge clk); #1;
    rd0 = 1'b1; wr0 = 1'b1;
    @(negedge clk);
    total++; if (busy_wait0 !== 1'b0) begin bad++; $display("FAIL ill_busy got=%b exp=0", busy_wait0); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin bad++; $display("FAIL ill_strobe got=%b%b exp=00", mem_read, mem_write); end
    end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL ill_err got=%b exp=1", err); end
    drop(0);
    repeat (3) @(negedge clk);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL ill_err_sticky got=%b exp=1", err); end
    do_reset();
    @(negedge clk);
    total++; if (err !== 1'b0) begin bad++; $display("FAIL ill_err_cleared got=%b exp=0", err); end
  endtask

  task automatic test_timeout();
    int run, cyc, stb;
    logic ok;
    do_reset();
    @(posedge clk); #1;
    stuck = 1'b1;
    req(0, 1'b0, 8'h30, 8'h00);
    run = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (mem_read) run++;
      else if (run > 0) break;
    end
    total++; if (run !== TO) begin bad++; $display("FAIL to_access_cycles got=%0d exp=%0d", run, TO); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL to_err got=%b exp=1", err); end
    total++; if (busy_wait0 !== 1'b1) begin bad++; $display("FAIL to_still_stalled got=%b exp=1", busy_wait0); end
    @(negedge clk);
    total++; if (mem_read !== 1'b1) begin bad++; $display("FAIL to_regrant got=%b exp=1", mem_read); end
    stuck = 1'b0;
    wait_port(0, cyc, stb, ok);
    total++; if (!ok || rdata0 !== 8'hC3) begin bad++; $display("FAIL to_recover got=%h ok=%b exp=c3", rdata0, ok); end
    drop(0);
  endtask

  task automatic test_reset_mid();
    int cyc, stb;
    logic ok;
    do_reset();
    @(posedge clk); #1;
    req(0, 1'b0, 8'h31, 8'h00);
    wait_port(0, cyc, stb, ok);
    drop(0);
    total++; if (!ok || rdata0 !== 8'h33) begin bad++; $display("FAIL rm_setup got=%h ok=%b exp=33", rdata0, ok); end
    @(posedge clk); #1;
    busy_cfg = 5;
    req(0, 1'b0, 8'h30, 8'h00);
    repeat (3) @(negedge clk);
    total++; if (mem_read !== 1'b1) begin bad++; $display("FAIL rm_in_access got=%b exp=1", mem_read); end
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    total++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin bad++; $display("FAIL rm_strobes got=%b%b exp=00", mem_read, mem_write); end
    total++; if (rdata0 !== 8'h00) begin bad++; $display("FAIL rm_rdata got=%h exp=00", rdata0); end
    for (int i = 0; i < 3; i++) begin
      total++; if (busy_wait0 !== 1'b1) begin bad++; $display("FAIL rm_no_done got=%b exp=1 step=%0d", busy_wait0, i); end
      @(negedge clk);
    end
    wait_port(0, cyc, stb, ok);
    total++; if (!ok || rdata0 !== 8'hC3) begin bad++; $display("FAIL rm_reaccess got=%h ok=%b exp=c3", rdata0, ok); end
    drop(0);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_illegal();
    test_timeout();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
